gcd_job_sequencer: RTL and testbench
====================================

// Module: gcd_job_sequencer
// PURPOSE
//  Upstream feeder and result collector for the subtractive GCD core. Accepts (A,B) operand pairs on a
//  valid/ready port and serialises them onto the core's shared 16-bit load bus: A, then B, with start.
//  Waits for core done, captures the result and presents it on a valid/ready output port.
//  Recycles the core for the next job. Zero operands bypass the core, which never terminates on them.
// PARAMETERS
//  W            16     operand/result width; must match core datapath width
//  TIMEOUT      4095   max cycles in WAIT before abort (used only with GCD_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    synchronous active-high reset
//  in_valid     in   1    operand pair valid
//  in_ready     out  1    sequencer can accept a pair
//  in_a         in   W    operand A
//  in_b         in   W    operand B
//  core_start   out  1    start strobe to GCD core
//  core_data    out  W    core load bus (data_in)
//  core_rst     out  1    returns core controller to its load state
//  core_done    in   1    core finished; result stable on core_result
//  core_result  in   W    core A register
//  res_valid    out  1    result valid
//  res_ready    in   1    consumer accepts result
//  res_data     out  W    gcd(A,B)
//  res_err      out  1    result aborted by timeout; valid only with res_valid
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0 in reset cycle, 1 from the next; core_start=0; core_data=0;
//   core_rst=1 during reset; res_valid=0; res_data=0; res_err=0; wait counter=0.
//  FSM (one-hot-safe, 3-bit encoding):
//   IDLE   : in_ready=1. On in_valid: latch a_q,b_q. If a==0 or b==0 go BYP, else go LOAD_A.
//   LOAD_A : core_data=a_q, core_start=1 for exactly this cycle -> LOAD_B.
//   LOAD_B : core_data=b_q, core_start=0 -> WAIT; counter cleared.
//   WAIT   : core_data holds b_q. On core_done: res_data<=core_result, res_err<=0 -> HOLD.
//            Otherwise counter increments.
//   BYP    : res_data <= a_q|b_q (gcd(0,x)=x; gcd(0,0)=0), res_err<=0 -> HOLD. Core untouched.
//   HOLD   : res_valid=1; res_data/res_err stable until res_ready=1. On handshake: go CLEAR
//            if the core was used, else IDLE.
//   CLEAR  : core_rst=1 for exactly one cycle -> IDLE.
//  in_ready is 1 only in IDLE. No overlap: one job in flight.
//  Latency (in handshake to res_valid): core path = 3 + core cycles; bypass = 2 cycles.
//  Back-to-back: a new pair is accepted no earlier than 1 cycle after CLEAR (2 after HOLD handshake).
//  core_done seen outside WAIT: ignored. in_valid outside IDLE: ignored (in_ready=0).
//  rst mid-job: abandon job, drop result, assert core_rst, return to IDLE; no res_valid emitted.
//  All arithmetic is W bits unsigned; no width growth.
// CONFIGURATION
//  GCD_SEQ_TIMEOUT_EN defined: in WAIT, when counter reaches TIMEOUT without core_done ->
//   res_data<=0, res_err<=1 -> HOLD, then CLEAR as normal. Counter is ceil(log2(TIMEOUT+1)) bits.
//  Not defined: no counter logic; WAIT waits indefinitely; res_err tied 0.
// STRUCTURE
//  Shared package gcd_pkg: state encodings (IDLE..CLEAR), default W=16.
//  Single module; no sub-module. Counter inline under the macro.
// TESTING
//  1. A=143,B=78 with core -> LOAD_A bus=143 start=1, LOAD_B bus=78; res_data=13, res_err=0.
//  2. A=0,B=25 -> no core_start, res_valid 2 cycles after accept, res_data=25. A=0,B=0 -> 0.
//  3. res_ready held 0 for 10 cycles -> res_valid/res_data stable, in_ready=0; then release -> CLEAR.
//     Next job: core_rst pulses 1 cycle, then in_ready=1.
//  4. Two jobs back-to-back (48,18)->6, (17,5)->1; each job has one core_rst between them.
//  5. rst asserted during WAIT -> no res_valid; core_rst=1; next job (100,75) -> 25.
//  6. GCD_SEQ_TIMEOUT_EN, TIMEOUT=20, stub core never done -> res_err=1, res_data=0 at cycle 20 of WAIT.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job sequencer: default datapath width and FSM state encoding.
package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_BYP    = 3'd4,
    ST_HOLD   = 3'd5,
    ST_CLEAR  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/gcd_job_sequencer.sv
// Feeds (A,B) pairs to the subtractive GCD core over its shared load bus and collects results.
// Optional wait watchdog: define GCD_SEQ_TIMEOUT_EN to abort a job after TIMEOUT cycles in WAIT.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 4095
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         core_start,
  output logic [W-1:0] core_data,
  output logic         core_rst,
  input  logic         core_done,
  input  logic [W-1:0] core_result,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err
);

  seq_state_t   state;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         core_used_q;
  logic         wd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b0;
      core_start  <= 1'b0;
      core_data   <= '0;
      core_rst    <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      core_used_q <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_rst   <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            a_q      <= in_a;
            b_q      <= in_b;
            // The core never terminates on a zero operand, so those jobs skip it entirely.
            if (in_a == '0 || in_b == '0) begin
              core_used_q <= 1'b0;
              state       <= ST_BYP;
            end else begin
              core_used_q <= 1'b1;
              core_data   <= in_a;
              core_start  <= 1'b1;
              state       <= ST_LOAD_A;
            end
          end
        end
        ST_LOAD_A: begin
          core_data <= b_q;
          state     <= ST_LOAD_B;
        end
        ST_LOAD_B: state <= ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            res_data  <= core_result;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end else if (wd_fire) begin
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_BYP: begin
          res_data  <= a_q | b_q;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (core_used_q) begin
              core_rst <= 1'b1;
              state    <= ST_CLEAR;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_CLEAR: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          core_rst <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires on the TIMEOUT-th WAIT cycle; the counter is zero on the first one.
  assign wd_fire = (state == ST_WAIT) && !core_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      res_err  <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (state == ST_WAIT || state == ST_BYP)
        res_err <= wd_fire;
    end
  end
`else
  // Watchdog compiled out: never fires, and results are never flagged as aborted.
  assign wd_fire = (TIMEOUT < 0);
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer with a behavioural subtractive-GCD core stub.
module tb_gcd_job_sequencer;

  localparam int W   = 16;
  localparam int TMO = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         core_start;
  logic [W-1:0] core_data;
  logic         core_rst;
  logic         core_done;
  logic [W-1:0] core_result;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit stall_core = 1'b0;
  bit spur_en    = 1'b0;
  bit spur_bit   = 1'b0;

  always #5 clk = ~clk;

  gcd_job_sequencer #(.W(W), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_rst    (core_rst),
    .core_done   (core_done),
    .core_result (core_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err)
  );

  // Core stub: loads A with start, B on the next cycle, then subtracts/swaps until B is zero.
  logic [W-1:0] sa = '0;
  logic [W-1:0] sb = '0;
  logic [1:0]   sph = 2'd0;

  always @(posedge clk) begin
    if (core_rst === 1'b1) sph <= 2'd0;
    else begin
      case (sph)
        2'd0: if (core_start === 1'b1) begin sa <= core_data; sph <= 2'd1; end
        2'd1: begin sb <= core_data; sph <= 2'd2; end
        default: if (sb != '0 && !stall_core) begin
          if (sa >= sb) sa <= sa - sb;
          else begin sa <= sb; sb <= sa; end
        end
      endcase
    end
  end

  assign core_done   = (sph == 2'd2 && sb == '0 && !stall_core) || (spur_en && spur_bit);
  assign core_result = sa;

  initial forever begin
    @(posedge clk); #1;
    spur_bit = 1'($urandom_range(0, 1));
  end

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks one job from acceptance to result handshake.
  bit           started = 1'b0, prev_rst = 1'b0, busy = 1'b0, held = 1'b0, clear_next = 1'b0;
  bit           jcore = 1'b0, jstall = 1'b0, jerr = 1'b0;
  logic [W-1:0] ja = '0, jb = '0, jg = '0;
  int           acc = 0;
  int           k = 0;

  always @(negedge clk) begin
    cyc++;
    if (!started) begin
      started = rst;
    end else if (prev_rst) begin
      chk("rst_in_ready",   32'(in_ready),   32'(0));
      chk("rst_core_rst",   32'(core_rst),   32'(1));
      chk("rst_core_start", 32'(core_start), 32'(0));
      chk("rst_core_data",  32'(core_data),  32'(0));
      chk("rst_res_valid",  32'(res_valid),  32'(0));
      chk("rst_res_data",   32'(res_data),   32'(0));
      chk("rst_res_err",    32'(res_err),    32'(0));
      busy = 1'b0; held = 1'b0; clear_next = 1'b0;
    end else if (rst) begin
      busy = 1'b0; held = 1'b0; clear_next = 1'b0;
    end else if (clear_next) begin
      chk("clear_core_rst",  32'(core_rst),   32'(1));
      chk("clear_in_ready",  32'(in_ready),   32'(0));
      chk("clear_res_valid", 32'(res_valid),  32'(0));
      chk("clear_start",     32'(core_start), 32'(0));
      clear_next = 1'b0;
    end else if (!busy) begin
      chk("idle_in_ready",  32'(in_ready),   32'(1));
      chk("idle_core_rst",  32'(core_rst),   32'(0));
      chk("idle_res_valid", 32'(res_valid),  32'(0));
      chk("idle_start",     32'(core_start), 32'(0));
      if (in_valid) begin
        ja     = in_a;
        jb     = in_b;
        jcore  = (in_a != '0) && (in_b != '0);
        jstall = stall_core && jcore;
        jg     = jstall ? '0 : gcd_ref(in_a, in_b);
        jerr   = jstall;
        acc    = cyc;
        busy   = 1'b1;
        held   = 1'b0;
      end
    end else begin
      k = cyc - acc;
      chk("busy_in_ready", 32'(in_ready), 32'(0));
      chk("busy_core_rst", 32'(core_rst), 32'(0));
      if (jcore) begin
        chk("core_start", 32'(core_start), 32'(k == 1));
        chk("core_data",  32'(core_data),  32'((k == 1) ? ja : jb));
        if (k <= 3) chk("core_latency", 32'(res_valid), 32'(0));
      end else begin
        chk("byp_no_start", 32'(core_start), 32'(0));
        if (k <= 2) chk("byp_latency", 32'(res_valid), 32'(k == 2));
      end
      if (jstall && k > 3 && k <= TMO + 3)
        chk("timeout_latency", 32'(res_valid), 32'(k == TMO + 3));
      if (held) chk("res_hold", 32'(res_valid), 32'(1));
      if (res_valid) begin
        chk("res_data", 32'(res_data), 32'(jg));
        chk("res_err",  32'(res_err),  32'(jerr));
      end
      held = res_valid && !res_ready;
      if (res_valid && res_ready) begin
        busy       = 1'b0;
        held       = 1'b0;
        clear_next = jcore;
      end else if (k > 6000) begin
        checks++; errors++;
        $display("FAIL job_timeout at cycle %0d: no result after %0d cycles, required within 6000", cyc, k);
        busy = 1'b0;
      end
    end
    prev_rst = rst;
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL in_ready_wait: in_ready=%0b after %0d cycles, required 1", in_ready, t);
    end
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         output logic [W-1:0] r, output bit e);
    int t;
    wait_ready();
    in_valid = 1'b1; in_a = a; in_b = b;
    spur_en  = (a == '0) || (b == '0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
    t = 0;
    while (res_valid !== 1'b1 && t < 6000) begin @(posedge clk); #1; t++; end
    if (res_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL res_wait: res_valid=%0b after %0d cycles, required 1", res_valid, t);
    end
    repeat (hold) begin @(posedge clk); #1; end
    r = res_data;
    e = res_err;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    spur_en   = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r, a, b;
    bit           e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("ref_143_78", 32'(gcd_ref(16'd143, 16'd78)), 32'(13));
    chk("ref_0_25",   32'(gcd_ref(16'd0, 16'd25)),   32'(25));
    chk("ref_0_0",    32'(gcd_ref(16'd0, 16'd0)),    32'(0));
    chk("ref_100_75", 32'(gcd_ref(16'd100, 16'd75)), 32'(25));

    run_job(16'd143, 16'd78, 0, r, e);  chk("t1_res", 32'(r), 32'(13)); chk("t1_err", 32'(e), 32'(0));
    run_job(16'd0, 16'd25, 0, r, e);    chk("t2_0_25", 32'(r), 32'(25));
    run_job(16'd0, 16'd0, 0, r, e);     chk("t2_0_0", 32'(r), 32'(0));
    run_job(16'hFFFF, 16'd0, 1, r, e);  chk("t2_max_0", 32'(r), 32'(65535));
    run_job(16'd21, 16'd14, 10, r, e);  chk("t3_hold", 32'(r), 32'(7));
    run_job(16'd48, 16'd18, 0, r, e);   chk("t4_48_18", 32'(r), 32'(6));
    run_job(16'd17, 16'd5, 0, r, e);    chk("t4_17_5", 32'(r), 32'(1));
    run_job(16'hFFFF, 16'hFFFF, 0, r, e); chk("max_max", 32'(r), 32'(65535));
    run_job(16'h8000, 16'h4000, 0, r, e); chk("pow2", 32'(r), 32'(16384));

    // Abandon a long core job with reset while it is in WAIT.
    wait_ready();
    in_valid = 1'b1; in_a = 16'd1000; in_b = 16'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      chk("t5_no_result", 32'(res_valid), 32'(0));
    end
    run_job(16'd100, 16'd75, 0, r, e);  chk("t5_after_rst", 32'(r), 32'(25));

`ifdef GCD_SEQ_TIMEOUT_EN
    stall_core = 1'b1;
    run_job(16'd9, 16'd6, 0, r, e);
    chk("t6_data", 32'(r), 32'(0));
    chk("t6_err",  32'(e), 32'(1));
    stall_core = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 5) == 0) ? '0 : 16'($urandom_range(1, 400));
      b = ($urandom_range(0, 5) == 0) ? '0 : 16'($urandom_range(1, 400));
      run_job(a, b, $urandom_range(0, 3), r, e);
      chk("rand_res", 32'(r), 32'(gcd_ref(a, b)));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: bench still running at cycle %0d, required to finish", cyc);
    $fatal(1, "global timeout");
  end

endmodule
